instr_fetch_ctrl: RTL and testbench

Instruction fetch controller that owns the program counter and sequences the single-port, combinational-read instruction memory. It issues one word read per cycle into a small prefetch FIFO and presents instructions to decode over a valid/ready handshake. It flushes and restarts on a redirect (branch/jump/trap) and halts on an out-of-range fetch address. It sits between the instruction memory and the decode stage of the CPU model.

---
 rtl/instr_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, issues one combinational
// memory read per cycle into a small prefetch FIFO of {pc, instr} entries,
// and hands the FIFO head to decode over a valid/ready handshake.
// A redirect flushes and restarts fetch; an out-of-range PC halts fetch and
// raises a sticky error until the next redirect.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MEM_WORDS  = 496
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        instr_mem_req_o,
    output logic [31:0] instr_mem_addr_o,
    input  logic [31:0] instr_mem_rd_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        fetch_err_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        FETCH,
        HALT
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic            err_q, err_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     pc_fifo_q    [FIFO_DEPTH];
    logic [31:0]     instr_fifo_q [FIFO_DEPTH];

    logic            in_range;
    logic            pop;
    logic            push;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    assign in_range         = ({2'b00, fetch_pc_q[31:2]} < MEM_WORDS);
    assign instr_valid_o    = (count_q != '0);
    assign pop              = instr_valid_o & instr_ready_i;
    // Gating with rst_ni keeps the request low while reset is held, since the
    // reset state itself would otherwise look like a fetchable cycle.
    assign instr_mem_req_o  = rst_ni & (state_q == FETCH) & ~redirect_i & in_range &
                              ((count_q < CW'(FIFO_DEPTH)) | pop);
    assign push             = instr_mem_req_o;
    assign instr_mem_addr_o = fetch_pc_q;
    assign instr_o          = instr_valid_o ? instr_fifo_q[rd_ptr_q] : '0;
    assign instr_pc_o       = instr_valid_o ? pc_fifo_q[rd_ptr_q]    : '0;
    assign fetch_err_o      = err_q;

    // Next-state: redirect has priority over everything, including halt.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        err_d      = err_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (redirect_i) begin
            state_d    = FETCH;
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            err_d      = 1'b0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if ((state_q == FETCH) && !in_range) begin
                state_d = HALT;
                err_d   = 1'b1;
            end
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            err_q      <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            err_q      <= err_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; contents need no reset because outputs are masked by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_fifo_q[wr_ptr_q]    <= fetch_pc_q;
            instr_fifo_q[wr_ptr_q] <= instr_mem_rd_data_i;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus random
// ready/redirect traffic, compared each cycle against a queue-based model.
module tb_instr_fetch_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MEM_WORDS = 496;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_mem_req_o;
    logic [31:0] instr_mem_addr_o;
    logic [31:0] instr_mem_rd_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        fetch_err_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_err;
    int unsigned req_seen;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if ({2'b00, a[31:2]} < MEM_WORDS)
            return 32'h1000_0000 + {2'b00, a[31:2]};
        return 32'hBAD0_BAD0;
    endfunction

    assign instr_mem_rd_data_i = mem_word(instr_mem_addr_o);

    instr_fetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH),
        .MEM_WORDS  (MEM_WORDS)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .instr_mem_req_o     (instr_mem_req_o),
        .instr_mem_addr_o    (instr_mem_addr_o),
        .instr_mem_rd_data_i (instr_mem_rd_data_i),
        .redirect_i          (redirect_i),
        .redirect_pc_i       (redirect_pc_i),
        .instr_valid_o       (instr_valid_o),
        .instr_o             (instr_o),
        .instr_pc_o          (instr_pc_o),
        .instr_ready_i       (instr_ready_i),
        .fetch_err_o         (fetch_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = RESET_PC;
        m_halt = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req"},   32'(instr_mem_req_o), 32'd0);
        check({pfx, "_addr"},  instr_mem_addr_o,     RESET_PC);
        check({pfx, "_valid"}, 32'(instr_valid_o),   32'd0);
        check({pfx, "_instr"}, instr_o,              32'd0);
        check({pfx, "_ipc"},   instr_pc_o,           32'd0);
        check({pfx, "_err"},   32'(fetch_err_o),     32'd0);
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic        e_valid, e_pop, e_req, e_inr;
        logic [31:0] e_instr, e_ipc;
        @(negedge clk_i);
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        #1;
        e_valid = (mq.size() != 0);
        e_instr = e_valid ? mq[0].ins : 32'd0;
        e_ipc   = e_valid ? mq[0].pc  : 32'd0;
        e_inr   = ({2'b00, m_pc[31:2]} < MEM_WORDS);
        e_pop   = e_valid & rdy;
        e_req   = !m_halt && !redir && e_inr && ((mq.size() < int'(DEPTH)) || e_pop);
        check("req",   32'(instr_mem_req_o), 32'(e_req));
        check("addr",  instr_mem_addr_o,     m_pc);
        check("valid", 32'(instr_valid_o),   32'(e_valid));
        check("instr", instr_o,              e_instr);
        check("ipc",   instr_pc_o,           e_ipc);
        check("err",   32'(fetch_err_o),     32'(m_err));
        if (instr_mem_req_o) req_seen++;
        if (redir) begin
            mq.delete();
            m_pc   = {rpc[31:2], 2'b00};
            m_halt = 1'b0;
            m_err  = 1'b0;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (e_req) begin
                mq.push_back('{pc: m_pc, ins: mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end else if (!m_halt && !e_inr) begin
                m_halt = 1'b1;
                m_err  = 1'b1;
            end
        end
    endtask

    task automatic run(input logic rdy, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(rdy, 1'b0, 32'd0);
    endtask

    initial begin
        logic        rdy, redir;
        logic [31:0] rpc;
        int unsigned sel;

        rst_ni        = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        model_reset();
        repeat (3) @(negedge clk_i);
        #1;
        check_reset_outputs("rst");

        // Release just after a rising edge so the next cycle is the first fetch cycle.
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Backpressure right after reset: exactly DEPTH requests, then stall.
        req_seen = 0;
        run(1'b0, 10);
        check("bp_reqs", req_seen, DEPTH);
        run(1'b1, 8);

        // Redirect to an unaligned address with three entries buffered.
        step(1'b1, 1'b1, 32'h0000_0040);
        run(1'b0, 3);
        check("pre_redir_valid", 32'(instr_valid_o), 32'd1);
        step(1'b0, 1'b1, 32'h0000_0103);
        run(1'b1, 6);

        // Fetch off the end of memory, halt, drain, then recover.
        step(1'b1, 1'b1, 32'h0000_07BC);
        run(1'b1, 6);
        check("halt_err", 32'(fetch_err_o), 32'd1);
        step(1'b1, 1'b1, 32'h0000_0000);
        run(1'b1, 5);

        // Redirect together with a pop while full.
        run(1'b0, 6);
        step(1'b1, 1'b1, 32'h0000_0200);
        run(1'b1, 6);

        // Random traffic.
        for (int unsigned i = 0; i < 2000; i++) begin
            rdy   = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 19) == 0);
            sel   = $urandom_range(0, 99);
            if (sel < 10)
                rpc = $urandom;
            else if (sel < 40)
                rpc = ((32'd490 + $urandom_range(0, 10)) << 2) | 32'($urandom_range(0, 3));
            else
                rpc = 32'($urandom_range(0, 2047));
            step(rdy, redir, rpc);
        end

        // Asynchronous reset in the middle of a stream.
        step(1'b1, 1'b1, 32'h0000_0300);
        run(1'b1, 4);
        check("pre_rst_valid", 32'(instr_valid_o), 32'd1);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        run(1'b1, 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
